epoch_scheduler: RTL and testbench
==================================

// Module: epoch_scheduler
// PURPOSE
//  Top-level training-loop sequencer for the network datapath. Runs TRAIN_N training samples,
//  then VAL_N validation samples, per epoch. Accumulates validation error and tracks the best
//  epoch. Requests a weight snapshot on each improvement. Stops on max epochs, on a patience
//  limit, or on abort. Sits between the host/config regs and the forward/backprop datapath.
// PARAMETERS
//  ERR_W     16  width of per-sample error, epoch accumulator and best_err
//  CNT_W     16  width of sample/epoch counters and config counts
//  PATIENCE  4   consecutive non-improving epochs before early stop (1..2^CNT_W-1)
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      pulse: latch config, begin run (ignored while busy)
//  abort        in   1      stop run at next edge (ignored in IDLE/DONE)
//  train_n      in   CNT_W  training samples per epoch (latched on start)
//  val_n        in   CNT_W  validation samples per epoch (latched on start)
//  max_epoch    in   CNT_W  epoch limit (latched on start)
//  sample_req   out  1      1-cycle pulse: datapath runs one sample
//  sample_val   out  1      valid with sample_req: 1=validation (no weight update), 0=train
//  sample_done  in   1      1-cycle pulse: datapath finished current sample
//  sample_err   in   ERR_W  error of finished sample, sampled only with sample_done in VAL_WAIT
//  snap_req     out  1      level: store current weights as best network
//  snap_ack     in   1      snapshot stored; snap_req drops next cycle
//  busy         out  1      1 in every state except IDLE/DONE
//  done         out  1      1 in DONE, held until next start or rst
//  stop_reason  out  2      0 none, 1 max_epoch, 2 patience, 3 abort; valid with done
//  epoch        out  CNT_W  completed epochs
//  best_err     out  ERR_W  lowest epoch validation error so far
//  best_epoch   out  CNT_W  epoch index (0-based) that produced best_err
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0, except best_err = {ERR_W{1}}. Internal counters/acc = 0.
//  States: IDLE, T_ISSUE, T_WAIT, V_ISSUE, V_WAIT, EVAL, SNAP, DONE.
//  Start, from IDLE/DONE:
//   - latch config; clear epoch, acc, patience cnt, stop_reason; best_err=all-ones.
//   - max_epoch==0 -> DONE, reason 1.
//   - else T_ISSUE; train_n==0 skips directly to V_ISSUE.
//  T_ISSUE/V_ISSUE: sample_req=1 for exactly this cycle -> *_WAIT next cycle.
//   First sample_req is the cycle after start (latency 1).
//  T_WAIT: on sample_done:
//   - sample cnt+1; if cnt==train_n -> V_ISSUE (val_n==0: EVAL), clear cnt.
//   - else T_ISSUE.
//  V_WAIT: on sample_done: acc = sat(acc + sample_err), clamp at all-ones, no wrap.
//   cnt+1; if cnt==val_n -> EVAL, else V_ISSUE.
//  sample_done outside *_WAIT is ignored. No sample_req is issued while waiting.
//  EVAL (1 cycle): epoch+1.
//   - val_n!=0 and acc < best_err (strict): best_err=acc, best_epoch=epoch (pre-increment),
//     patience cnt=0 -> SNAP.
//   - else patience cnt+1.
//   - then, if not SNAP: epoch+1==max_epoch -> DONE r1; patience==PATIENCE -> DONE r2;
//     else T_ISSUE. acc cleared.
//   - val_n==0: never improves, and patience never counts.
//  SNAP: snap_req=1 until snap_ack. On ack -> same max_epoch check as EVAL, else T_ISSUE.
//   snap_ack outside SNAP ignored.
//  abort in any busy state -> DONE r3 next edge; beats all other transitions.
//   In SNAP, abort drops snap_req without waiting for ack.
//  rst mid-run: immediate return to reset values at the edge; sample_req/snap_req deassert.
//  Equal error (acc==best_err) is not an improvement. max_epoch and patience hit together
//   in EVAL -> reason 1.
// STRUCTURE
//  Shared package nn_pkg:
//   - state enum (3-bit) and STOP_NONE/STOP_MAX/STOP_PAT/STOP_ABORT constants.
//   - ERR_W/CNT_W defaults shared with the validation/error blocks.
//  One sub-module: sat_accum (ERR_W saturating add with clear/enable). The FSM and counters
//   stay in this module.
// TESTING
//  1 train_n=2,val_n=1,max_epoch=1, err=5 -> 3 sample_req (val flags 0,0,1);
//    best_err=5, best_epoch=0, snap_req until ack, done r1, epoch=1.
//  2 val errs per epoch 9,7,7,8,8,8 with PATIENCE=4,max_epoch=10 -> snaps after ep0,ep1;
//    done r2 at epoch=6, best_err=7, best_epoch=1.
//  3 val_n=3, errs 0xFFF0,0x0020,0x0001 -> acc saturates 0xFFFF;
//    not < best(0xFFFF) -> no snap.
//  4 abort asserted in V_WAIT and again in SNAP (no ack) -> done r3 next cycle,
//    snap_req=0, epoch unchanged.
//  5 max_epoch=0 -> done r1 one cycle after start, no sample_req. train_n=0 -> first req has
//    sample_val=1. start while busy ignored.
//  6 rst asserted mid T_WAIT -> all outputs reset values next cycle; spurious sample_done/
//    snap_ack in IDLE cause no change.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the training-loop sequencer and the validation/error blocks.
package nn_pkg;

  localparam int ERR_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_T_ISSUE = 3'd1,
    S_T_WAIT  = 3'd2,
    S_V_ISSUE = 3'd3,
    S_V_WAIT  = 3'd4,
    S_EVAL    = 3'd5,
    S_SNAP    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [1:0] STOP_NONE  = 2'd0;
  localparam logic [1:0] STOP_MAX   = 2'd1;
  localparam logic [1:0] STOP_PAT   = 2'd2;
  localparam logic [1:0] STOP_ABORT = 2'd3;

endpackage

// File: rtl/epoch_scheduler_if.sv
// Sample and snapshot handshakes between the scheduler (master) and the datapath (slave).
interface epoch_scheduler_if import nn_pkg::*; #(
  parameter int ERR_W = ERR_W_DEF
) ();
  logic             sample_req;
  logic             sample_val;
  logic             sample_done;
  logic [ERR_W-1:0] sample_err;
  logic             snap_req;
  logic             snap_ack;

  modport master (
    output sample_req, sample_val, snap_req,
    input  sample_done, sample_err, snap_ack
  );

  modport slave (
    input  sample_req, sample_val, snap_req,
    output sample_done, sample_err, snap_ack
  );
endinterface

// File: rtl/epoch_scheduler_sat_accum.sv
// Saturating validation-error accumulator: clamps at all-ones instead of wrapping.
module sat_accum #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ERR_W-1:0] din,
  output logic [ERR_W-1:0] acc
);

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [ERR_W-1:0] b);
    logic [ERR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sat_add(acc, din);
    end
  end

endmodule

// File: rtl/epoch_scheduler.sv
// Training-loop sequencer: train/validate per epoch, track best epoch, snapshot and early stop.
module epoch_scheduler import nn_pkg::*; #(
  parameter int ERR_W    = ERR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PATIENCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] train_n,
  input  logic [CNT_W-1:0] val_n,
  input  logic [CNT_W-1:0] max_epoch,
  epoch_scheduler_if.master dp,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stop_reason,
  output logic [CNT_W-1:0] epoch,
  output logic [ERR_W-1:0] best_err,
  output logic [CNT_W-1:0] best_epoch
);

  localparam logic [CNT_W-1:0] PAT_LIM = CNT_W'(PATIENCE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] epoch_q, epoch_d;
  logic [CNT_W-1:0] pat_q, pat_d;
  logic [ERR_W-1:0] best_err_q, best_err_d;
  logic [CNT_W-1:0] best_epoch_q, best_epoch_d;
  logic [1:0]       reason_q, reason_d;
  logic [CNT_W-1:0] cfg_train_q, cfg_train_d;
  logic [CNT_W-1:0] cfg_val_q, cfg_val_d;
  logic [CNT_W-1:0] cfg_max_q, cfg_max_d;
  logic             acc_clr, acc_en;
  logic [ERR_W-1:0] acc;
  logic             busy_w;

  // An epoch with no training samples opens straight into validation, or evaluation if both are empty.
  function automatic state_t first_state(input logic [CNT_W-1:0] tn,
                                         input logic [CNT_W-1:0] vn);
    if (tn != '0)      return S_T_ISSUE;
    else if (vn != '0) return S_V_ISSUE;
    else               return S_EVAL;
  endfunction

  sat_accum #(.ERR_W(ERR_W)) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .din (dp.sample_err),
    .acc (acc)
  );

  assign busy_w = (state_q != S_IDLE) && (state_q != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      epoch_q      <= '0;
      pat_q        <= '0;
      best_err_q   <= '1;
      best_epoch_q <= '0;
      reason_q     <= STOP_NONE;
      cfg_train_q  <= '0;
      cfg_val_q    <= '0;
      cfg_max_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      epoch_q      <= epoch_d;
      pat_q        <= pat_d;
      best_err_q   <= best_err_d;
      best_epoch_q <= best_epoch_d;
      reason_q     <= reason_d;
      cfg_train_q  <= cfg_train_d;
      cfg_val_q    <= cfg_val_d;
      cfg_max_q    <= cfg_max_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    epoch_d      = epoch_q;
    pat_d        = pat_q;
    best_err_d   = best_err_q;
    best_epoch_d = best_epoch_q;
    reason_d     = reason_q;
    cfg_train_d  = cfg_train_q;
    cfg_val_d    = cfg_val_q;
    cfg_max_d    = cfg_max_q;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;

    // Abort outranks every other transition, including a pending snapshot.
    if (busy_w && abort) begin
      state_d  = S_DONE;
      reason_d = STOP_ABORT;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cfg_train_d  = train_n;
            cfg_val_d    = val_n;
            cfg_max_d    = max_epoch;
            cnt_d        = '0;
            epoch_d      = '0;
            pat_d        = '0;
            best_err_d   = '1;
            best_epoch_d = '0;
            reason_d     = STOP_NONE;
            acc_clr      = 1'b1;
            if (max_epoch == '0) begin
              state_d  = S_DONE;
              reason_d = STOP_MAX;
            end else begin
              state_d = first_state(train_n, val_n);
            end
          end
        end
        S_T_ISSUE: state_d = S_T_WAIT;
        S_V_ISSUE: state_d = S_V_WAIT;
        S_T_WAIT: begin
          if (dp.sample_done) begin
            if (cnt_q + 1'b1 == cfg_train_q) begin
              cnt_d   = '0;
              state_d = (cfg_val_q == '0) ? S_EVAL : S_V_ISSUE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = S_T_ISSUE;
            end
          end
        end
        S_V_WAIT: begin
          if (dp.sample_done) begin
            acc_en = 1'b1;
            if (cnt_q + 1'b1 == cfg_val_q) begin
              cnt_d   = '0;
              state_d = S_EVAL;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = S_V_ISSUE;
            end
          end
        end
        S_EVAL: begin
          acc_clr = 1'b1;
          epoch_d = epoch_q + 1'b1;
          if ((cfg_val_q != '0) && (acc < best_err_q)) begin
            best_err_d   = acc;
            best_epoch_d = epoch_q;
            pat_d        = '0;
            state_d      = S_SNAP;
          end else begin
            if (cfg_val_q != '0) pat_d = pat_q + 1'b1;
            if (epoch_q + 1'b1 == cfg_max_q) begin
              state_d  = S_DONE;
              reason_d = STOP_MAX;
            end else if (pat_d == PAT_LIM) begin
              state_d  = S_DONE;
              reason_d = STOP_PAT;
            end else begin
              state_d = first_state(cfg_train_q, cfg_val_q);
            end
          end
        end
        S_SNAP: begin
          if (dp.snap_ack) begin
            if (epoch_q == cfg_max_q) begin
              state_d  = S_DONE;
              reason_d = STOP_MAX;
            end else begin
              state_d = first_state(cfg_train_q, cfg_val_q);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign dp.sample_req = (state_q == S_T_ISSUE) || (state_q == S_V_ISSUE);
  assign dp.sample_val = (state_q == S_V_ISSUE);
  assign dp.snap_req   = (state_q == S_SNAP);
  assign busy          = busy_w;
  assign done          = (state_q == S_DONE);
  assign stop_reason   = reason_q;
  assign epoch         = epoch_q;
  assign best_err      = best_err_q;
  assign best_epoch    = best_epoch_q;

endmodule

// File: tb/tb_epoch_scheduler.sv
// Directed bench for epoch_scheduler acting as host and forward/backprop datapath.
module tb_epoch_scheduler;
  import nn_pkg::*;

  localparam int ERR_W = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] train_n;
  logic [CNT_W-1:0] val_n;
  logic [CNT_W-1:0] max_epoch;
  logic             busy;
  logic             done;
  logic [1:0]       stop_reason;
  logic [CNT_W-1:0] epoch;
  logic [ERR_W-1:0] best_err;
  logic [CNT_W-1:0] best_epoch;

  int errors = 0;
  int checks = 0;

  epoch_scheduler_if #(.ERR_W(ERR_W)) sif ();

  epoch_scheduler #(.ERR_W(ERR_W), .CNT_W(CNT_W), .PATIENCE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .train_n     (train_n),
    .val_n       (val_n),
    .max_epoch   (max_epoch),
    .dp          (sif),
    .busy        (busy),
    .done        (done),
    .stop_reason (stop_reason),
    .epoch       (epoch),
    .best_err    (best_err),
    .best_epoch  (best_epoch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_rsn"},   32'(stop_reason), 32'd0);
    chk({tag, "_epoch"}, 32'(epoch), 32'd0);
    chk({tag, "_best"},  32'(best_err), 32'hFFFF);
    chk({tag, "_bep"},   32'(best_epoch), 32'd0);
    chk({tag, "_req"},   32'(sif.sample_req), 32'd0);
    chk({tag, "_val"},   32'(sif.sample_val), 32'd0);
    chk({tag, "_snap"},  32'(sif.snap_req), 32'd0);
  endtask

  task automatic do_start(input int tn, input int vn, input int me);
    train_n   = CNT_W'(tn);
    val_n     = CNT_W'(vn);
    max_epoch = CNT_W'(me);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!sif.sample_req && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(sif.sample_req), 32'd1);
  endtask

  // One datapath sample: accept the request, idle a cycle, then report completion.
  task automatic do_sample(input string tag, input logic exp_val, input int err);
    wait_req(tag);
    chk({tag, "_val"}, 32'(sif.sample_val), 32'(exp_val));
    tick();
    chk({tag, "_wait"}, 32'(sif.sample_req), 32'd0);
    sif.sample_done = 1'b1;
    sif.sample_err  = ERR_W'(err);
    tick();
    sif.sample_done = 1'b0;
    sif.sample_err  = '0;
  endtask

  task automatic snap_seq(input string tag);
    chk({tag, "_snap_on"}, 32'(sif.snap_req), 32'd1);
    tick();
    chk({tag, "_snap_hold"}, 32'(sif.snap_req), 32'd1);
    sif.snap_ack = 1'b1;
    tick();
    sif.snap_ack = 1'b0;
    chk({tag, "_snap_off"}, 32'(sif.snap_req), 32'd0);
  endtask

  int e2[6]     = '{9, 7, 7, 8, 8, 8};
  bit imp2[6]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    train_n = '0; val_n = '0; max_epoch = '0;
    sif.sample_done = 1'b0; sif.sample_err = '0; sif.snap_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("rst0");

    // 1: two train samples, one validation sample, single epoch
    do_start(2, 1, 1);
    chk("t1_latency", 32'(sif.sample_req), 32'd1);
    do_sample("t1_s0", 1'b0, 0);
    do_sample("t1_s1", 1'b0, 0);
    do_sample("t1_s2", 1'b1, 5);
    tick();
    chk("t1_best",  32'(best_err), 32'd5);
    chk("t1_bep",   32'(best_epoch), 32'd0);
    chk("t1_epoch_snap", 32'(epoch), 32'd1);
    snap_seq("t1");
    chk("t1_done",  32'(done), 32'd1);
    chk("t1_rsn",   32'(stop_reason), 32'd1);
    chk("t1_epoch", 32'(epoch), 32'd1);
    chk("t1_busy",  32'(busy), 32'd0);
    chk("t1_noreq", 32'(sif.sample_req), 32'd0);

    // 2: improvements at epochs 0,1 then four stale epochs trip patience
    do_start(1, 1, 10);
    for (int k = 0; k < 6; k++) begin
      do_sample($sformatf("t2_tr%0d", k), 1'b0, 0);
      do_sample($sformatf("t2_va%0d", k), 1'b1, e2[k]);
      tick();
      chk($sformatf("t2_snap%0d", k), 32'(sif.snap_req), 32'(imp2[k]));
      if (imp2[k]) snap_seq($sformatf("t2_ack%0d", k));
    end
    chk("t2_done",  32'(done), 32'd1);
    chk("t2_rsn",   32'(stop_reason), 32'd2);
    chk("t2_epoch", 32'(epoch), 32'd6);
    chk("t2_best",  32'(best_err), 32'd7);
    chk("t2_bep",   32'(best_epoch), 32'd1);

    // 3: accumulator saturates at all-ones, which equals best and is no improvement
    do_start(1, 3, 1);
    do_sample("t3_tr", 1'b0, 0);
    do_sample("t3_v0", 1'b1, 16'hFFF0);
    do_sample("t3_v1", 1'b1, 16'h0020);
    do_sample("t3_v2", 1'b1, 16'h0001);
    tick();
    chk("t3_snap",  32'(sif.snap_req), 32'd0);
    chk("t3_done",  32'(done), 32'd1);
    chk("t3_rsn",   32'(stop_reason), 32'd1);
    chk("t3_best",  32'(best_err), 32'hFFFF);
    chk("t3_epoch", 32'(epoch), 32'd1);

    // 4a: abort while waiting on a validation sample
    do_start(1, 1, 5);
    do_sample("t4_tr", 1'b0, 0);
    wait_req("t4_v");
    chk("t4_vflag", 32'(sif.sample_val), 32'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4a_done",  32'(done), 32'd1);
    chk("t4a_rsn",   32'(stop_reason), 32'd3);
    chk("t4a_epoch", 32'(epoch), 32'd0);
    chk("t4a_busy",  32'(busy), 32'd0);
    chk("t4a_req",   32'(sif.sample_req), 32'd0);

    // 4b: abort during a snapshot with no ack
    do_start(1, 1, 5);
    do_sample("t4b_tr", 1'b0, 0);
    do_sample("t4b_va", 1'b1, 3);
    tick();
    chk("t4b_snap_on", 32'(sif.snap_req), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4b_snap_off", 32'(sif.snap_req), 32'd0);
    chk("t4b_done",     32'(done), 32'd1);
    chk("t4b_rsn",      32'(stop_reason), 32'd3);
    chk("t4b_epoch",    32'(epoch), 32'd1);

    // 5a: zero epoch limit finishes immediately
    do_start(1, 1, 0);
    chk("t5a_done", 32'(done), 32'd1);
    chk("t5a_rsn",  32'(stop_reason), 32'd1);
    chk("t5a_req",  32'(sif.sample_req), 32'd0);
    chk("t5a_busy", 32'(busy), 32'd0);
    tick();
    chk("t5a_req2", 32'(sif.sample_req), 32'd0);

    // 5b: no training samples, and a start while busy is ignored
    do_start(0, 1, 1);
    chk("t5b_req",  32'(sif.sample_req), 32'd1);
    chk("t5b_val",  32'(sif.sample_val), 32'd1);
    tick();
    max_epoch = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5b_busy", 32'(busy), 32'd1);
    chk("t5b_done", 32'(done), 32'd0);
    sif.sample_done = 1'b1;
    sif.sample_err  = 16'd4;
    tick();
    sif.sample_done = 1'b0;
    tick();
    snap_seq("t5b");
    chk("t5b_fin",   32'(done), 32'd1);
    chk("t5b_rsn",   32'(stop_reason), 32'd1);
    chk("t5b_epoch", 32'(epoch), 32'd1);
    chk("t5b_best",  32'(best_err), 32'd4);

    // 6: reset in the middle of a training wait, then stray handshakes in IDLE
    do_start(1, 1, 5);
    do_sample("t6_tr0", 1'b0, 0);
    do_sample("t6_va0", 1'b1, 6);
    tick();
    snap_seq("t6_e0");
    do_sample("t6_tr1", 1'b0, 0);
    do_sample("t6_va1", 1'b1, 5);
    tick();
    snap_seq("t6_e1");
    chk("t6_bep_pre",   32'(best_epoch), 32'd1);
    chk("t6_epoch_pre", 32'(epoch), 32'd2);
    wait_req("t6_tr2");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("t6_rst");
    sif.sample_done = 1'b1;
    sif.sample_err  = 16'd1;
    sif.snap_ack    = 1'b1;
    tick();
    sif.sample_done = 1'b0;
    sif.sample_err  = '0;
    sif.snap_ack    = 1'b0;
    tick();
    check_reset("t6_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
